// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with a per-register busy
// scoreboard for a dual-issue decode stage. Reads are combinational, with
// optional forwarding of same-cycle writes. Busy bits are set at issue,
// cleared at writeback and flushed on pipeline flush. Register 0 is
// hardwired to zero and is never busy.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR-1:0]          set_en,
  input  logic [NUM_WR*ADDR_W-1:0]   set_addr,
  input  logic                       flush,
  output logic [NUM_REGS-1:0]        busy_vec
);

  // Register storage is flops rather than RAM: the whole file must clear
  // asynchronously and be readable combinationally on several ports.
  logic [DATA_W-1:0]   regs_reg  [NUM_REGS];
  logic [DATA_W-1:0]   regs_next [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Merge write ports into next register state; ascending loop order makes
  // the highest-index port win on an address conflict. r0 stays zero.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_next[r] = regs_reg[r];
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k]) begin
        regs_next[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
      end
    end
    regs_next[0] = '0;
  end

  // Busy update: writeback clears, issue sets (set wins as the younger
  // producer), flush clears everything and overrides issue. r0 never busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (set_en[k]) begin
        set_vec[set_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
      end
      if (wr_en[k]) begin
        clr_vec[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    set_vec[0] = 1'b0;
    if (flush) begin
      busy_next = '0;
    end else begin
      busy_next = (busy_reg & ~clr_vec) | set_vec;
    end
    busy_next[0] = 1'b0;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_reg[r] <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_reg[r] <= regs_next[r];
      end
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

  // One combinational read port per instance.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit;
      logic [DATA_W-1:0] fwd;
      logic [DATA_W-1:0] data_c;
      logic              busy_c;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      // Find the forwarding source (highest-index matching write port),
      // then pick forwarded or stored data and the effective busy flag.
      always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == addr)) begin
            hit = 1'b1;
            fwd = wr_data[k*DATA_W +: DATA_W];
          end
        end
        if (addr == '0) begin
          data_c = '0;
          busy_c = 1'b0;
        end else if ((BYPASS != 0) && hit) begin
          // Writeback in flight this cycle: consumer need not stall.
          data_c = fwd;
          busy_c = 1'b0;
        end else begin
          data_c = regs_reg[addr];
          busy_c = busy_reg[addr];
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data_c;
      assign rd_busy[gi]                  = busy_c;
    end
  endgenerate

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-port general-purpose register file with an integrated per-register busy scoreboard, serving the dual-issue decode stage. It provides NUM_RD combinational read ports, NUM_WR prioritised write ports with optional same-cycle write-to-read bypass, and a busy bit per register. Busy bits are set when an instruction that writes a destination issues, and cleared on writeback. Decode uses the per-port busy outputs to stall on RAW hazards.

## Interface
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: number of architectural registers (power of two, ≥2).
- ADDR_W, 5: register address width, equal to log2(NUM_REGS).
- NUM_RD, 4: number of read ports.
- NUM_WR, 2: number of write ports and issue (set) ports.
- BYPASS, 1: 1 routes same-cycle write data to matching reads; 0 disables forwarding.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-low.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational.
- rd_busy  out  NUM_RD  1 = the addressed register has a pending producer.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- set_en  in  NUM_WR  issue-time busy-set enables.
- set_addr  in  NUM_WR*ADDR_W  destination registers to mark busy.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- busy_vec  out  NUM_REGS  raw scoreboard state, for debug and cover points.

## Operation
- Register 0:
  - Reads return 0 and rd_busy reads 0.
  - Writes and sets to register 0 are ignored.
  - Its busy bit is never set.
- Read data, BYPASS=1: if any enabled write port has a nonzero address equal to the read address, rd_data is that port's wr_data. Otherwise rd_data is the stored value.
- Read data, BYPASS=0: rd_data is always the stored value.
- Write priority: when several enabled write ports target the same nonzero address, the highest-index port wins and the others are dropped. The same rule selects the bypass source.
- Writes to distinct addresses all commit in the same cycle.
- Busy set: each set_en[j] with a nonzero set_addr sets that register's busy bit at the next edge.
- Busy clear: each wr_en[k] with a nonzero wr_addr clears that register's busy bit at the next edge.
- Set and clear of the same register in the same cycle: set wins. The issuing instruction is the new, younger producer.
- flush: clears all busy bits at the next edge and overrides set_en in that cycle. Writes still commit normally.
- rd_busy:
  - BYPASS=1: rd_busy = busy bit AND NOT (same-cycle write hit on that address), so a consumer reading during writeback does not stall.
  - BYPASS=0: rd_busy = busy bit.
- The block does not count multiple outstanding producers. Decode must not issue a second writer to a busy register (WAW). A bench assertion flags set_en to an address whose busy bit is already set.

## Timing
- Reset assertion, immediately and asynchronously:
  - All registers become 0.
  - All busy bits become 0.
  - busy_vec = 0.
  - rd_data = 0 and rd_busy = 0, unless BYPASS forwards a concurrent write.
- Reset deassertion: the first write or set commits at the first rising edge after reset goes high.
- Reset asserted mid-cycle discards any write or set that has not yet committed.
- Read latency: 0 cycles (combinational from rd_addr and the stored state).
- Write latency: a write committed at edge N is visible in stored data from N onward. With BYPASS=1 it is also visible combinationally in the cycle before edge N.
- Busy set at edge N: rd_busy is high from edge N until the clearing write's cycle. With BYPASS=1 rd_busy drops in the write's own cycle; with BYPASS=0 it drops after that write's edge.
- Combinational paths: rd_addr/wr_* → rd_data/rd_busy. No combinational path from set_en or flush to any output.

## Test plan
- Reset/read-zero: assert reset with registers holding data, then release, then read all 32 addresses → rd_data=0 and rd_busy=0 on every port.
- Dual-write conflict: wr_en=2'b11, wr_addr={5,5}, wr_data={0xBBBB_0002, 0xAAAA_0001} → next cycle r5 reads 0xBBBB_0002. In the same cycle, BYPASS=1 reads of r5 return 0xBBBB_0002.
- Register 0 immunity: write 0xFFFF_FFFF to r0 and set_en on r0 → reads of r0 return 0, rd_busy=0, busy_vec[0]=0.
- Scoreboard lifecycle: set r7 at edge 1 → rd_busy=1 from edge 1. Write r7=0x1234 in cycle 4 → BYPASS=1: rd_busy=0 and rd_data=0x1234 in cycle 4; BYPASS=0: both change after edge 5.
- Set/clear collision and flush: same-cycle write r9 and set r9 → busy_vec[9]=1 after the edge. Then flush together with set r3 → busy_vec=0 after the edge.
- Async reset mid-write: assert reset between edges while wr_en targets r12 → r12=0 and busy_vec=0 immediately; no write commits while reset is low.
